// File: rtl/mem_block_responder_if.sv
// Request/response bus between the cache miss FSMs and the main-memory responder.
// The requester side uses the master modport; the memory side uses slave.
interface mem_block_responder_if;
  logic        req_en;
  logic        req_ready;
  logic        req_wr;
  logic        req_burst;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [15:0] rsp_addr;
  logic        rsp_last;
  logic [3:0]  inflight;

  modport master (
    output req_en, req_wr, req_burst, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_last, inflight
  );

  modport slave (
    input  req_en, req_wr, req_burst, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_last, inflight
  );
endinterface

// File: rtl/mem_block_responder.sv
// Fixed-latency main-memory responder: single-word reads/writes plus aligned
// block-fill bursts, fully pipelined with one read beat issued per cycle.
module mem_block_responder #(
  parameter int    DEPTH_LOG2 = 10,
  parameter int    LATENCY    = 4,
  parameter int    BURST_LEN  = 8,
  parameter string INIT_FILE  = ""
) (
  input  logic clk,
  input  logic rst,
  mem_block_responder_if.slave bus
);
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int STAGES = LATENCY - 1;
  localparam int CW     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [15:0] BASE_MASK = ~16'(2 * BURST_LEN - 1);

  typedef enum logic {IDLE, BURST} state_t;

  logic [15:0] mem [DEPTH];

  state_t      state, nextState;
  logic [CW-1:0] cnt, cntNext;
  logic [15:0] baseReg, baseNext;

  logic        issue, issueLast, memWr;
  logic [15:0] issueAddr, rdData, beatOff;

  logic [STAGES:0]       vldPipe, lastPipe;
  logic [STAGES:0][15:0] addrPipe, dataPipe;

  assign bus.req_ready = (state == IDLE);
  assign beatOff       = 16'(cnt) << 1;
  // Only one request is accepted per edge, so a read never shares an edge with
  // a write and the plain array read already gives read-after-write order.
  assign rdData        = mem[issueAddr[DEPTH_LOG2:1]];

  always_comb begin
    issue     = 1'b0;
    issueLast = 1'b0;
    issueAddr = '0;
    memWr     = 1'b0;
    nextState = state;
    cntNext   = cnt;
    baseNext  = baseReg;
    case (state)
      IDLE: begin
        if (bus.req_en) begin
          if (bus.req_wr) begin
            memWr = 1'b1;
          end else if (bus.req_burst) begin
            issue     = 1'b1;
            issueAddr = bus.req_addr & BASE_MASK;
            issueLast = (BURST_LEN == 1);
            baseNext  = bus.req_addr & BASE_MASK;
            if (BURST_LEN > 1) begin
              nextState = BURST;
              cntNext   = CW'(1);
            end
          end else begin
            issue     = 1'b1;
            issueAddr = {bus.req_addr[15:1], 1'b0};
            issueLast = 1'b1;
          end
        end
      end
      BURST: begin
        issue     = 1'b1;
        issueAddr = baseReg + beatOff;
        issueLast = (cnt == CW'(BURST_LEN - 1));
        cntNext   = cnt + CW'(1);
        if (issueLast) begin
          nextState = IDLE;
          cntNext   = '0;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Array is deliberately left out of reset so committed writes survive it.
  always_ff @(posedge clk) begin
    if (memWr) mem[bus.req_addr[DEPTH_LOG2:1]] <= bus.req_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      baseReg       <= '0;
      vldPipe       <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_last  <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_addr  <= '0;
      bus.inflight  <= '0;
    end else begin
      state      <= nextState;
      cnt        <= cntNext;
      baseReg    <= baseNext;
      vldPipe[0] <= issue;
      for (int i = 1; i <= STAGES; i++) vldPipe[i] <= vldPipe[i-1];
      bus.rsp_valid <= vldPipe[STAGES];
      bus.rsp_last  <= vldPipe[STAGES] & lastPipe[STAGES];
      if (vldPipe[STAGES]) begin
        bus.rsp_data <= dataPipe[STAGES];
        bus.rsp_addr <= addrPipe[STAGES];
      end
      // Retire counts at the edge that launches rsp_valid, capping at LATENCY.
      bus.inflight <= bus.inflight + 4'(issue) - 4'(vldPipe[STAGES]);
    end
  end

  always_ff @(posedge clk) begin
    addrPipe[0] <= issueAddr;
    dataPipe[0] <= rdData;
    lastPipe[0] <= issueLast;
    for (int i = 1; i <= STAGES; i++) begin
      addrPipe[i] <= addrPipe[i-1];
      dataPipe[i] <= dataPipe[i-1];
      lastPipe[i] <= lastPipe[i-1];
    end
  end
endmodule
